// File: rtl/char_hproj_bounds_pkg.sv
// Shared image-process definitions: default frame geometry and the band-tracker state encoding.
package char_hproj_bounds_pkg;

    localparam int IMG_HDISP_DEF = 640;
    localparam int IMG_VDISP_DEF = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        IN_BAND = 2'd2,
        CLOSE   = 2'd3
    } band_state_e;

endpackage

// File: rtl/char_hproj_bounds_if.sv
// Binary video stream: input frame/line/pixel strobes plus their 1-cycle-delayed copies.
interface char_hproj_bounds_if;

    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;
    logic per_img_bit;

    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_bit;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
    );

endinterface

// File: rtl/char_hproj_bounds_row_pixel_counter.sv
// Per-row foreground counter: x position, column window gate, saturating accumulator, hot flag.
module row_pixel_counter #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clken,
    input  logic          pix,
    input  logic          line_end,
    input  logic          frame_start,
    input  logic [CW-1:0] col_start,
    input  logic [CW-1:0] col_end,
    input  logic [CW-1:0] row_thresh,
    output logic          row_hot
);

    localparam logic [CW-1:0] ACC_MAX = '1;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] acc_q, acc_d;
    logic          in_win;

    // An inverted window (col_start >= col_end) can never satisfy both bounds.
    always_comb begin
        in_win = (x_q >= col_start) && (x_q < col_end);
        x_d    = x_q;
        acc_d  = acc_q;
        if (frame_start || line_end) begin
            x_d   = '0;
            acc_d = '0;
        end else if (clken) begin
            x_d = x_q + 1'b1;
            if (in_win && pix && (acc_q != ACC_MAX)) begin
                acc_d = acc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            acc_q <= '0;
        end else begin
            x_q   <= x_d;
            acc_q <= acc_d;
        end
    end

    assign row_hot = (acc_q >= row_thresh);

endmodule

// File: rtl/char_hproj_bounds.sv
// Horizontal-projection band finder: locates the longest run of "hot" rows in a binary frame
// and reports its first/last row once per completed frame.
module char_hproj_bounds
    import char_hproj_bounds_pkg::*;
#(
    parameter int IMG_HDISP = IMG_HDISP_DEF,
    parameter int IMG_VDISP = IMG_VDISP_DEF,
    parameter int CW        = 10,
    parameter int MIN_BAND  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    char_hproj_bounds_if.slave vid,
    input  logic [CW-1:0]      col_start,
    input  logic [CW-1:0]      col_end,
    input  logic [CW-1:0]      row_thresh,
    output logic [CW-1:0]      band_top,
    output logic [CW-1:0]      band_bottom,
    output logic               band_valid,
    output logic               result_stb
);

    localparam int MAX_DIM = (IMG_HDISP > IMG_VDISP) ? IMG_HDISP : IMG_VDISP;
    localparam logic [CW-1:0] MIN_LEN = CW'(MIN_BAND);

    if ((2 ** CW) <= MAX_DIM) begin : g_cw_too_narrow
        $error("CW too narrow for the configured image size");
    end

    logic vsync_q, vsync_d, href_q, href_d, clken_q, clken_d, bit_q, bit_d;
    logic armed_q, armed_d;
    band_state_e state_q, state_d;
    logic [CW-1:0] y_q, y_d, cur_top_q, cur_top_d;
    logic [CW-1:0] best_top_q, best_top_d, best_bot_q, best_bot_d, best_len_q, best_len_d;
    logic          best_valid_q, best_valid_d;
    logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, row_thresh_q, row_thresh_d;
    logic [CW-1:0] band_top_q, band_top_d, band_bot_q, band_bot_d;
    logic          band_valid_q, band_valid_d, result_stb_q, result_stb_d;

    logic          frame_start, frame_end, line_end, row_hot;
    logic          close_run;
    logic [CW-1:0] run_top, run_len;

    // armed_q blocks a false frame start when reset releases while vsync is already high.
    assign frame_start = vid.per_frame_vsync & ~vsync_q & armed_q;
    assign frame_end   = ~vid.per_frame_vsync & vsync_q;
    assign line_end    = ~vid.per_frame_href & href_q;

    row_pixel_counter #(.CW(CW)) u_row_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clken       (vid.per_frame_clken),
        .pix         (vid.per_img_bit),
        .line_end    (line_end),
        .frame_start (frame_start),
        .col_start   (col_start_q),
        .col_end     (col_end_q),
        .row_thresh  (row_thresh_q),
        .row_hot     (row_hot)
    );

    always_comb begin
        vsync_d      = vid.per_frame_vsync;
        href_d       = vid.per_frame_href;
        clken_d      = vid.per_frame_clken;
        bit_d        = vid.per_img_bit;
        armed_d      = armed_q | ~vid.per_frame_vsync;
        state_d      = state_q;
        y_d          = line_end ? (y_q + 1'b1) : y_q;
        cur_top_d    = cur_top_q;
        best_top_d   = best_top_q;
        best_bot_d   = best_bot_q;
        best_len_d   = best_len_q;
        best_valid_d = best_valid_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        row_thresh_d = row_thresh_q;
        band_top_d   = band_top_q;
        band_bot_d   = band_bot_q;
        band_valid_d = band_valid_q;
        result_stb_d = 1'b0;
        close_run    = 1'b0;
        run_top      = cur_top_q;
        run_len      = '0;

        // On frame end the row ending in the same cycle is folded into the run before closing.
        unique case (state_q)
            IDLE: ;
            SEARCH: begin
                if (frame_end) begin
                    if (line_end && row_hot) begin
                        close_run = 1'b1;
                        run_top   = y_q;
                        run_len   = CW'(1);
                    end
                    state_d = CLOSE;
                end else if (line_end && row_hot) begin
                    cur_top_d = y_q;
                    state_d   = IN_BAND;
                end
            end
            IN_BAND: begin
                if (frame_end) begin
                    close_run = 1'b1;
                    run_len   = y_q - cur_top_q + CW'(line_end && row_hot);
                    state_d   = CLOSE;
                end else if (line_end && !row_hot) begin
                    close_run = 1'b1;
                    run_len   = y_q - cur_top_q;
                    state_d   = SEARCH;
                end
            end
            CLOSE: begin
                state_d = IDLE;
                if (!frame_start) begin
                    band_top_d   = best_top_q;
                    band_bot_d   = best_bot_q;
                    band_valid_d = best_valid_q;
                    result_stb_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strictly longer wins, so an equal-length later run never displaces the earlier one.
        if (close_run && (run_len >= MIN_LEN) && (!best_valid_q || (run_len > best_len_q))) begin
            best_top_d   = run_top;
            best_bot_d   = run_top + run_len - CW'(1);
            best_len_d   = run_len;
            best_valid_d = 1'b1;
        end

        if (frame_start) begin
            state_d      = SEARCH;
            y_d          = '0;
            best_top_d   = '0;
            best_bot_d   = '0;
            best_len_d   = '0;
            best_valid_d = 1'b0;
            col_start_d  = col_start;
            col_end_d    = col_end;
            row_thresh_d = row_thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            clken_q      <= 1'b0;
            bit_q        <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            y_q          <= '0;
            cur_top_q    <= '0;
            best_top_q   <= '0;
            best_bot_q   <= '0;
            best_len_q   <= '0;
            best_valid_q <= 1'b0;
            col_start_q  <= '0;
            col_end_q    <= '0;
            row_thresh_q <= '0;
            band_top_q   <= '0;
            band_bot_q   <= '0;
            band_valid_q <= 1'b0;
            result_stb_q <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            clken_q      <= clken_d;
            bit_q        <= bit_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            y_q          <= y_d;
            cur_top_q    <= cur_top_d;
            best_top_q   <= best_top_d;
            best_bot_q   <= best_bot_d;
            best_len_q   <= best_len_d;
            best_valid_q <= best_valid_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            row_thresh_q <= row_thresh_d;
            band_top_q   <= band_top_d;
            band_bot_q   <= band_bot_d;
            band_valid_q <= band_valid_d;
            result_stb_q <= result_stb_d;
        end
    end

    assign vid.post_frame_vsync = vsync_q;
    assign vid.post_frame_href  = href_q;
    assign vid.post_frame_clken = clken_q;
    assign vid.post_img_bit     = bit_q;
    assign band_top             = band_top_q;
    assign band_bottom          = band_bot_q;
    assign band_valid           = band_valid_q;
    assign result_stb           = result_stb_q;

endmodule

// File: tb/tb_char_hproj_bounds.sv
// Directed bench for char_hproj_bounds: band selection, frame-end timing, abort and reset cases.
module tb_char_hproj_bounds;
    import char_hproj_bounds_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] col_start, col_end, row_thresh;
    logic [9:0] band_top, band_bottom;
    logic       band_valid, result_stb;

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;
    int c0;

    logic [3:0] prev_in = '0;
    logic       prev_ok = 1'b0;

    char_hproj_bounds_if vif ();

    char_hproj_bounds dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vid         (vif),
        .col_start   (col_start),
        .col_end     (col_end),
        .row_thresh  (row_thresh),
        .band_top    (band_top),
        .band_bottom (band_bottom),
        .band_valid  (band_valid),
        .result_stb  (result_stb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && result_stb) stb_cnt++;
    end

    // post_* must be the inputs seen one clock earlier
    always @(negedge clk) begin
        if (rst_n && prev_ok)
            check_eq("post_delay", {vif.post_frame_vsync, vif.post_frame_href,
                                    vif.post_frame_clken, vif.post_img_bit}, prev_in);
        prev_in = {vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken, vif.per_img_bit};
        prev_ok = rst_n;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Config is driven with the vsync rise, then scrambled so only the sampled copy is valid.
    task automatic frame_begin(input int cs, input int ce, input int th);
        step();
        col_start  = 10'(cs);
        col_end    = 10'(ce);
        row_thresh = 10'(th);
        vif.per_frame_vsync = 1'b1;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_bit     = 1'b0;
        step();
        col_start  = 10'd600;
        col_end    = 10'd10;
        row_thresh = 10'd1000;
    endtask

    // Cold rows are sent as 1-pixel lines; only clken pixels reach the row counter.
    task automatic frame_rows(input int rows, input int a_lo, input int a_hi, input int b_lo,
                              input int b_hi, input int x0, input int n_ones, input int n_pix,
                              input bit coin);
        logic hot;
        int   np;
        for (int y = 0; y < rows; y++) begin
            hot = ((y >= a_lo) && (y <= a_hi)) || ((y >= b_lo) && (y <= b_hi));
            np  = hot ? n_pix : 1;
            for (int x = 0; x < np; x++) begin
                step();
                vif.per_frame_href  = 1'b1;
                vif.per_frame_clken = 1'b1;
                vif.per_img_bit     = hot && (x >= x0) && (x < x0 + n_ones);
            end
            step();
            vif.per_frame_href  = 1'b0;
            vif.per_frame_clken = 1'b0;
            vif.per_img_bit     = 1'b0;
            if (coin && (y == rows - 1)) vif.per_frame_vsync = 1'b0;
        end
    endtask

    task automatic frame_finish(input bit dropped, input int et, input int eb, input int ev,
                                input string tag);
        if (!dropped) begin
            step();
            vif.per_frame_vsync = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_stb_fall"}, result_stb, 0);
        @(negedge clk);
        check_eq({tag, "_stb_close"}, result_stb, 0);
        @(negedge clk);
        check_eq({tag, "_stb"}, result_stb, 1);
        check_eq({tag, "_top"}, band_top, et);
        check_eq({tag, "_bottom"}, band_bottom, eb);
        check_eq({tag, "_valid"}, band_valid, ev);
        @(negedge clk);
        check_eq({tag, "_stb_after"}, result_stb, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        col_start = '0; col_end = '0; row_thresh = '0;
        vif.per_frame_vsync = 1'b0;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_bit     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_top", band_top, 0);
        check_eq("rst_bottom", band_bottom, 0);
        check_eq("rst_valid", band_valid, 0);
        check_eq("rst_stb", result_stb, 0);
        check_eq("rst_post_vsync", vif.post_frame_vsync, 0);
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
        step();
        rst_n = 1'b1;
        repeat (3) step();

        c0 = stb_cnt;
        frame_begin(0, 640, 30);
        frame_rows(480, 100, 139, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 100, 139, 1, "single_band");
        check_eq("single_band_stb_count", stb_cnt - c0, 1);
        repeat (5) @(negedge clk);
        check_eq("hold_top", band_top, 100);
        check_eq("hold_bottom", band_bottom, 139);

        frame_begin(0, 640, 30);
        frame_rows(480, 10, 14, 200, 219, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 200, 219, 1, "short_then_long");

        frame_begin(0, 640, 30);
        frame_rows(480, 10, 14, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 0, 0, 0, "short_only");

        frame_begin(0, 640, 30);
        frame_rows(480, 50, 59, 300, 309, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 50, 59, 1, "equal_runs");

        frame_begin(100, 640, 30);
        frame_rows(480, 50, 59, 300, 309, 0, 100, 110, 1'b0);
        frame_finish(1'b0, 0, 0, 0, "outside_window");

        frame_begin(0, 640, 30);
        frame_rows(480, 470, 479, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 470, 479, 1, "band_at_end");

        frame_begin(0, 640, 30);
        frame_rows(480, 470, 479, -1, -1, 0, 50, 52, 1'b1);
        frame_finish(1'b1, 470, 479, 1, "coincident_end");

        frame_begin(0, 640, 0);
        frame_rows(480, -1, -1, -1, -1, 0, 0, 1, 1'b0);
        frame_finish(1'b0, 0, 479, 1, "thresh_zero");

        frame_begin(50, 10, 1);
        frame_rows(480, 100, 139, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 0, 0, 0, "empty_window");

        c0 = stb_cnt;
        frame_begin(0, 640, 30);
        frame_rows(200, 50, 69, -1, -1, 0, 50, 52, 1'b0);
        step();
        vif.per_frame_vsync = 1'b0;
        frame_begin(0, 640, 30);
        frame_rows(480, 100, 119, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 100, 119, 1, "after_abort");
        check_eq("abort_stb_count", stb_cnt - c0, 1);

        frame_begin(0, 640, 30);
        frame_rows(120, 100, 139, -1, -1, 0, 50, 52, 1'b0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_top", band_top, 0);
        check_eq("midrst_bottom", band_bottom, 0);
        check_eq("midrst_valid", band_valid, 0);
        check_eq("midrst_state", 32'(dut.state_q), 32'(IDLE));
        step();
        step();
        rst_n = 1'b1;
        c0 = stb_cnt;
        frame_rows(360, 0, 19, -1, -1, 0, 50, 52, 1'b0);
        step();
        vif.per_frame_vsync = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("midrst_no_stb", stb_cnt - c0, 0);
        check_eq("midrst_valid_kept", band_valid, 0);
        frame_begin(0, 640, 30);
        frame_rows(480, 100, 139, -1, -1, 0, 50, 52, 1'b0);
        frame_finish(1'b0, 100, 139, 1, "after_reset");
        check_eq("after_reset_stb_count", stb_cnt - c0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
